// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide writeback sequencer:
// datapath sizes, instruction field positions, opcode/aluop constants,
// FSM state encoding and small instruction-decode helpers.
package multdiv_sequencer_pkg;

    localparam int ITER  = 32;
    localparam int WIDTH = 32;

    localparam logic [4:0] OPC_ALU   = 5'b00000;
    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 27;
    localparam int RD_MSB    = 26;
    localparam int RD_LSB    = 22;
    localparam int RS_MSB    = 21;
    localparam int RS_LSB    = 17;
    localparam int RT_MSB    = 16;
    localparam int RT_LSB    = 12;
    localparam int ALUOP_MSB = 6;
    localparam int ALUOP_LSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ir);
        return ir[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ir);
        return ir[RT_MSB:RT_LSB];
    endfunction

    function automatic logic f_is_mul(input logic [31:0] ir);
        return (ir[OPC_MSB:OPC_LSB] == OPC_ALU) && (ir[ALUOP_MSB:ALUOP_LSB] == ALUOP_MUL);
    endfunction

    function automatic logic f_is_div(input logic [31:0] ir);
        return (ir[OPC_MSB:OPC_LSB] == OPC_ALU) && (ir[ALUOP_MSB:ALUOP_LSB] == ALUOP_DIV);
    endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Pipeline-side bundle of the mul/div writeback unit.
//   slave  : the sequencer (consumes DX/FD state, produces writeback + stall)
//   master : the pipeline / register-file control side
interface multdiv_sequencer_if;
    import multdiv_sequencer_pkg::*;

    logic [WIDTH-1:0] DXIR;
    logic             dxValid;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic [WIDTH-1:0] FDIR;
    logic [WIDTH-1:0] PWIR;
    logic             multOrDivReady;
    logic [WIDTH-1:0] result;
    logic             exception;
    logic             busy;
    logic             stall;

    modport slave (
        input  DXIR, dxValid, operandA, operandB, FDIR,
        output PWIR, multOrDivReady, result, exception, busy, stall
    );

    modport master (
        output DXIR, dxValid, operandA, operandB, FDIR,
        input  PWIR, multOrDivReady, result, exception, busy, stall
    );

endinterface

// File: rtl/multdiv_sequencer_datapath.sv
// Iterative signed multiply / divide datapath, one iteration per i_step.
// Ports:
//   clock, reset_n       : clock, async active-low reset
//   i_load               : capture operands and operation type
//   i_is_div             : 1 = divide, 0 = multiply
//   i_op_a, i_op_b       : signed operands (A*B or A/B)
//   i_step               : perform one shift-add / restoring-subtract step
//   o_result, o_exception: sign-corrected result, valid after ITER steps
module multdiv_datapath
    import multdiv_sequencer_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_result,
    output logic             o_exception
);

    logic               r_is_div;
    logic               r_neg;
    logic               r_div_zero;
    logic               r_div_ovf;
    logic [WIDTH-1:0]   r_mag_b;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] r_acc;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod_signed;
    logic [WIDTH-1:0]   w_quot_signed;
    logic               w_mul_ovf;

    assign w_mag_a = i_op_a[WIDTH-1] ? (~i_op_a + WIDTH'(1)) : i_op_a;
    assign w_mag_b = i_op_b[WIDTH-1] ? (~i_op_b + WIDTH'(1)) : i_op_b;

    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mag_b};
    assign w_trial   = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_mag_b};

    always_comb begin
        w_acc_next = r_acc;
        if (r_is_div) begin
            // Remainder stays below the divisor (<= 2^31), so the bit
            // dropped by the plain shift on a failed trial is always zero.
            if (w_trial[WIDTH]) begin
                w_acc_next = {r_acc[2*WIDTH-2:0], 1'b0};
            end else begin
                w_acc_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end
        end else if (r_acc[0]) begin
            w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        end else begin
            w_acc_next = {1'b0, r_acc[2*WIDTH-1:1]};
        end
    end

    assign w_prod_signed = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
    assign w_quot_signed = r_neg ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];
    // Product fits in WIDTH bits only if the upper half plus the result sign bit agree.
    assign w_mul_ovf = ~((&w_prod_signed[2*WIDTH-1:WIDTH-1]) | ~(|w_prod_signed[2*WIDTH-1:WIDTH-1]));

    always_comb begin
        o_result    = w_prod_signed[WIDTH-1:0];
        o_exception = w_mul_ovf;
        if (r_is_div) begin
            if (r_div_zero) begin
                o_result    = '0;
                o_exception = 1'b1;
            end else begin
                o_result    = w_quot_signed;
                o_exception = r_div_ovf;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_is_div   <= 1'b0;
            r_neg      <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_mag_b    <= '0;
            r_acc      <= '0;
        end else if (i_load) begin
            r_is_div   <= i_is_div;
            r_neg      <= i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1];
            r_div_zero <= (i_op_b == '0);
            r_div_ovf  <= (i_op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_op_b == '1);
            r_mag_b    <= w_mag_b;
            r_acc      <= {{WIDTH{1'b0}}, w_mag_a};
        end else if (i_step) begin
            r_acc      <= w_acc_next;
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Mul/div writeback sequencer: captures a mul/div leaving DX, runs the
// iterative datapath for ITER cycles, presents PWIR/result for one
// writeback cycle and stalls FD/DX on structural, RAW and WAW hazards.
// Ports:
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : DXIR/dxValid/operands/FDIR in; PWIR, multOrDivReady,
//                    result, exception, busy, stall out
//
// state | meaning
// IDLE  | nothing outstanding
// RUN   | iterating, counter 0..ITER-1
// DONE  | writeback cycle, multOrDivReady=1; may accept the next op
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    multdiv_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(ITER);

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_pwir;
    logic [WIDTH-1:0]   r_result;
    logic               r_exception;

    logic               w_busy;
    logic               w_done;
    logic               w_pending;
    logic               w_last;
    logic               w_dx_md;
    logic [4:0]         w_pw_rd;
    logic               w_hazard_raw;
    logic               w_hazard_waw;
    logic               w_stall;
    logic               w_start;
    logic [WIDTH-1:0]   w_dp_result;
    logic               w_dp_exception;

    assign w_busy    = (r_state == ST_RUN);
    assign w_done    = (r_state == ST_DONE);
    assign w_pending = w_busy | w_done;
    assign w_last    = (r_count == CNT_W'(ITER-1));

    assign w_dx_md      = f_is_mul(bus.DXIR) | f_is_div(bus.DXIR);
    assign w_pw_rd      = f_rd(r_pwir);
    assign w_hazard_raw = (f_rs(bus.FDIR) == w_pw_rd) | (f_rt(bus.FDIR) == w_pw_rd);
    assign w_hazard_waw = ~w_dx_md & (f_rd(bus.DXIR) == w_pw_rd);
    // A mul/div in DX during DONE is accepted, so only RUN blocks it.
    assign w_stall = (w_busy & w_dx_md)
                   | (w_pending & (w_pw_rd != 5'd0) & (w_hazard_raw | w_hazard_waw));
    assign w_start = bus.dxValid & w_dx_md & ~w_stall;

    multdiv_datapath u_datapath (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_load      (w_start),
        .i_is_div    (f_is_div(bus.DXIR)),
        .i_op_a      (bus.operandA),
        .i_op_b      (bus.operandB),
        .i_step      (w_busy),
        .o_result    (w_dp_result),
        .o_exception (w_dp_exception)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)  w_state_next = ST_DONE;
            ST_DONE: w_state_next = w_start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_pwir      <= '0;
            r_result    <= '0;
            r_exception <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_pwir  <= bus.DXIR;
                r_count <= '0;
            end else if (w_busy) begin
                r_count <= r_count + CNT_W'(1);
            end
            // Hold the written-back value once the datapath is reloaded.
            if (w_done) begin
                r_result    <= w_dp_result;
                r_exception <= w_dp_exception;
            end
        end
    end

    assign bus.PWIR           = r_pwir;
    assign bus.multOrDivReady = w_done;
    assign bus.result         = w_done ? w_dp_result : r_result;
    assign bus.exception      = w_done ? w_dp_exception : r_exception;
    assign bus.busy           = w_busy;
    assign bus.stall          = w_stall;

endmodule
